// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the bin_to_bcd8 converter.
package bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [31:0] MAX_UNSIGNED = 32'd99_999_999;
  localparam logic [31:0] MAX_NEG      = 32'd9_999_999;

  localparam logic [3:0] DIG_DASH = 4'hC;
  localparam logic [3:0] DIG_ERR  = 4'hE;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin_to_bcd8.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving
// eight display digits. Define BCD_SIGN_EN to treat Bin as two's complement.
module bin_to_bcd8
  import bcd_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [BIN_W-1:0] Bin,
  output logic             Busy,
  output logic             Done,
  output logic             Ovf,
  output logic [3:0]       Digital1,
  output logic [3:0]       Digital2,
  output logic [3:0]       Digital3,
  output logic [3:0]       Digital4,
  output logic [3:0]       Digital5,
  output logic [3:0]       Digital6,
  output logic [3:0]       Digital7,
  output logic [3:0]       Digital8
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           r_state;
  logic [BIN_W-1:0] r_sh;
  logic [31:0]      r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_ovf_pend;
  logic             r_done;
  logic             r_ovf;
  logic [31:0]      r_dig;

  logic [BIN_W:0]   w_mag;
  logic             w_neg;
  logic [31:0]      w_limit;
  logic             w_ovf;
  logic [31:0]      w_adj;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_neg = 1'b0;
    w_mag = {1'b0, Bin};
`ifdef BCD_SIGN_EN
    // One extra bit keeps the magnitude of the most-negative input representable.
    w_neg = Bin[BIN_W-1];
    if (w_neg) w_mag = -{Bin[BIN_W-1], Bin};
`endif
    w_limit = w_neg ? MAX_NEG : MAX_UNSIGNED;
    w_ovf   = 32'(w_mag) > w_limit;
  end

  for (genvar g = 0; g < 8; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_d (r_shadow[4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_sh       <= '0;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_dig      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_sh       <= w_mag[BIN_W-1:0];
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_neg      <= w_neg;
            r_ovf_pend <= w_ovf;
            r_state    <= w_ovf ? ST_DONE : ST_CONV;
          end
        end
        ST_CONV: begin
          r_shadow <= {w_adj[30:0], r_sh[BIN_W-1]};
          r_sh     <= r_sh << 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (r_ovf_pend)  r_dig <= {8{DIG_ERR}};
          else if (r_neg)  r_dig <= {DIG_DASH, r_shadow[27:0]};
          else             r_dig <= r_shadow;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (r_state != ST_IDLE);
  assign Done     = r_done;
  assign Ovf      = r_ovf;
  assign Digital1 = r_dig[3:0];
  assign Digital2 = r_dig[7:4];
  assign Digital3 = r_dig[11:8];
  assign Digital4 = r_dig[15:12];
  assign Digital5 = r_dig[19:16];
  assign Digital6 = r_dig[23:20];
  assign Digital7 = r_dig[27:24];
  assign Digital8 = r_dig[31:28];

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Scoreboard bench for bin_to_bcd8: stimulus queues expected digits/Ovf/Done cycle,
// a monitor pops and compares on every Done pulse.
module tb_bin_to_bcd8;

  localparam int BIN_W = 27;

  typedef struct {
    logic [31:0] dig;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy, done, ovf;
  logic [3:0]       d1, d2, d3, d4, d5, d6, d7, d8;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q[$];

  bin_to_bcd8 #(.BIN_W(BIN_W)) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Start    (start),
    .Bin      (bin),
    .Busy     (busy),
    .Done     (done),
    .Ovf      (ovf),
    .Digital1 (d1),
    .Digital2 (d2),
    .Digital3 (d3),
    .Digital4 (d4),
    .Digital5 (d5),
    .Digital6 (d6),
    .Digital7 (d7),
    .Digital8 (d8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [31:0] digits = {d8, d7, d6, d5, d4, d3, d2, d1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pops one expectation; digits must not move between Dones.
  exp_t        m_e;
  logic [31:0] m_prev  = '0;
  logic        m_early = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev  = '0;
      m_early = 1'b0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          m_e = q.pop_front();
          check("digits", digits, m_e.dig);
          check("ovf", {31'd0, ovf}, {31'd0, m_e.ovf});
          check("done_cycle", cyc, m_e.cyc);
          check("digits_stable_before_done", {31'd0, m_early}, 32'd0);
        end
        m_early = 1'b0;
      end else if (digits != m_prev) begin
        m_early = 1'b1;
      end
      m_prev = digits;
    end
  end

  // Drives one Start pulse; returns the accepting edge number.
  task automatic issue(input logic [BIN_W-1:0] b, input logic [31:0] dig,
                       input logic o, input bit push, output int acc);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    acc   = cyc + 1;
    if (push) q.push_back('{dig, o, acc + (o ? 1 : BIN_W + 1)});
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    check("drain_timeout", q.size(), 32'd0);
    q.delete();
    @(negedge clk);
    check("done_is_pulse", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic convert(input logic [BIN_W-1:0] b, input logic [31:0] dig, input logic o);
    int acc;
    issue(b, dig, o, 1'b1, acc);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    convert(BIN_W'(12345678), 32'h12345678, 1'b0);

    // Start pulses at edges 5 and 20 of a conversion must be ignored.
    issue(BIN_W'(24681357), 32'h24681357, 1'b0, 1'b1, a);
    while (cyc < a + 4) @(negedge clk);
    start = 1'b1; bin = BIN_W'(99);
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 19) @(negedge clk);
    start = 1'b1; bin = BIN_W'(77);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high: re-accepted exactly BIN_W+2 edges later.
    @(negedge clk);
    start = 1'b1;
    bin   = BIN_W'(123);
    a     = cyc + 1;
    q.push_back('{32'h123, 1'b0, a + BIN_W + 1});
    q.push_back('{32'h456, 1'b0, a + 2 * BIN_W + 3});
    while (cyc < a + 10) @(negedge clk);
    bin = BIN_W'(456);
    while (cyc < a + BIN_W + 2) @(negedge clk);
    start = 1'b0;
    check("busy_reaccepted", {31'd0, busy}, 32'd1);
    drain();

`ifndef BCD_SIGN_EN
    convert(BIN_W'(99999999), 32'h99999999, 1'b0);
    convert(BIN_W'(100000000), 32'hEEEEEEEE, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_held", {31'd0, ovf}, 32'd1);
    convert(BIN_W'(0), 32'h0, 1'b0);
`else
    convert(BIN_W'(-32'sd1234567), 32'hC1234567, 1'b0);
    convert(BIN_W'(-32'sd10000000), 32'hEEEEEEEE, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_held", {31'd0, ovf}, 32'd1);
    convert(BIN_W'(-32'sd9999999), 32'hC9999999, 1'b0);
    convert({1'b1, {(BIN_W-1){1'b0}}}, 32'hEEEEEEEE, 1'b1);
    convert(BIN_W'(0), 32'h0, 1'b0);
`endif
    convert(BIN_W'(5), 32'h5, 1'b0);

    // Reset in the middle of a conversion discards it.
    issue(BIN_W'(12345678), 32'h0, 1'b0, 1'b0, a);
    while (cyc < a + 9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_digits", digits, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BIN_W + 10) @(negedge clk);
    check("midrst_stays_idle", {31'd0, busy}, 32'd0);
    convert(BIN_W'(12345678), 32'h12345678, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
